// File: rtl/pipe_reg_pkg.sv
// Shared types for the pipe_reg stage register.
// The skid entry is built only when PIPE_REG_SKID_EN is defined.
package pipe_reg_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } pipe_state_t;

    localparam int PIPE_LEVEL_W = 2;

endpackage

// File: rtl/pipe_reg.sv
// Valid/ready pipeline register with flush and optional skid entry.
// Define PIPE_REG_SKID_EN for the two-entry, registered-ready variant.
module pipe_reg
    import pipe_reg_pkg::*;
#(
    parameter int unsigned      WIDTH = 32,
    parameter logic [WIDTH-1:0] INIT  = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [WIDTH-1:0]        in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [PIPE_LEVEL_W-1:0] level
);

    pipe_state_t      state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic             in_beat, out_beat;

`ifdef PIPE_REG_SKID_EN
    logic [WIDTH-1:0] skid_q, skid_d;

    // Depends on state only, so no combinational path from out_ready.
    assign in_ready = (state_q != TWO);
`else
    assign in_ready = !out_valid || out_ready;
`endif

    assign out_valid = (state_q != EMPTY);
    assign out_data  = main_q;
    assign level     = PIPE_LEVEL_W'(state_q);
    assign in_beat   = in_valid && in_ready;
    assign out_beat  = out_valid && out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
`ifdef PIPE_REG_SKID_EN
        skid_d  = skid_q;
`endif
        if (flush) begin
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (in_beat) begin
                        state_d = ONE;
                        main_d  = in_data;
                    end
                end
                ONE: begin
                    if (in_beat && out_beat) begin
                        main_d = in_data;
                    end else if (out_beat) begin
                        state_d = EMPTY;
`ifdef PIPE_REG_SKID_EN
                    end else if (in_beat) begin
                        state_d = TWO;
                        skid_d  = in_data;
`endif
                    end
                end
`ifdef PIPE_REG_SKID_EN
                TWO: begin
                    if (out_beat) begin
                        state_d = ONE;
                        main_d  = skid_q;
                    end
                end
`endif
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            main_q  <= INIT;
`ifdef PIPE_REG_SKID_EN
            skid_q  <= INIT;
`endif
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
`ifdef PIPE_REG_SKID_EN
            skid_q  <= skid_d;
`endif
        end
    end

endmodule
